// File: rtl/mips_pkg.sv
// Shared register-file constants for the writeback path.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : mips_pkg

// File: rtl/wb_md_fifo.sv
// Synchronous FIFO holding queued mul/div results as {waddr, wdata} entries.
// Head entry is visible combinationally so the arbiter can pop it in the same cycle.
module wb_md_fifo
    import mips_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [ADDR_W-1:0]        i_push_waddr,
    input  logic [DATA_W-1:0]        i_push_wdata,
    input  logic                     i_pop,
    output logic [ADDR_W-1:0]        o_head_waddr,
    output logic [DATA_W-1:0]        o_head_wdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

    // Full/empty guards live here as well so a misbehaving caller cannot corrupt pointers.
    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;

    assign {o_head_waddr, o_head_wdata} = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && do_push) begin
            mem_q[wr_ptr_q] <= {i_push_waddr, i_push_wdata};
        end
    end

endmodule : wb_md_fifo

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: ALU results win the regfile write port, mul/div results queue and drain
// when the ALU is idle or stalled. Same-cycle read bypass is built when WB_BYPASS_EN is defined.
module wb_write_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W     = REG_DATA_W,
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int MD_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_alu_valid,
    input  logic [ADDR_W-1:0]          i_alu_waddr,
    input  logic [DATA_W-1:0]          i_alu_wdata,
    input  logic                       i_md_valid,
    output logic                       o_md_ready,
    input  logic [ADDR_W-1:0]          i_md_waddr,
    input  logic [DATA_W-1:0]          i_md_wdata,
    output logic                       o_alu_stall,
    output logic                       o_we,
    output logic [ADDR_W-1:0]          o_waddr,
    output logic [DATA_W-1:0]          o_wdata,
    output logic [$clog2(MD_DEPTH):0]  o_md_count,
    input  logic [ADDR_W-1:0]          i_raddr1,
    input  logic [ADDR_W-1:0]          i_raddr2,
    output logic                       o_fwd1_hit,
    output logic [DATA_W-1:0]          o_fwd1_data,
    output logic                       o_fwd2_hit,
    output logic [DATA_W-1:0]          o_fwd2_data
);

    localparam int ST_W = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic              md_push;
    logic              md_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] head_waddr;
    logic [DATA_W-1:0] head_wdata;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ST_W-1:0]   starve_q, starve_d;
    logic              stall_q, stall_d;

    // Readiness depends only on occupancy: a full FIFO gets no credit from a same-cycle pop.
    assign o_md_ready = ~i_rst & ~fifo_full;
    assign md_push    = i_md_valid & o_md_ready;
    assign md_pop     = ~i_alu_valid & ~fifo_empty;

    wb_md_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (MD_DEPTH)
    ) u_md_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (md_push),
        .i_push_waddr (i_md_waddr),
        .i_push_wdata (i_md_wdata),
        .i_pop        (md_pop),
        .o_head_waddr (head_waddr),
        .o_head_wdata (head_wdata),
        .o_full       (fifo_full),
        .o_empty      (fifo_empty),
        .o_count      (o_md_count)
    );

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (i_alu_valid) begin
            we_d    = (i_alu_waddr != ZERO_ADDR);
            waddr_d = i_alu_waddr;
            wdata_d = i_alu_wdata;
        end else if (md_pop) begin
            we_d    = (head_waddr != ZERO_ADDR);
            waddr_d = head_waddr;
            wdata_d = head_wdata;
        end
    end

    // Starve count saturates; stall is registered alongside it so it drops the cycle after a pop.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || md_pop) begin
            starve_d = '0;
        end else if (i_alu_valid && (starve_q != ST_W'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
        stall_d = (starve_d == ST_W'(STARVE_MAX));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign o_we        = we_q;
    assign o_waddr     = waddr_q;
    assign o_wdata     = wdata_q;
    assign o_alu_stall = stall_q;

`ifdef WB_BYPASS_EN
    logic [1:0][ADDR_W-1:0] raddr;
    logic [1:0]             fwd_hit;
    logic [1:0][DATA_W-1:0] fwd_data;

    assign raddr = {i_raddr2, i_raddr1};

    for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
        assign fwd_hit[gi]  = we_q & (waddr_q == raddr[gi]) & (raddr[gi] != ZERO_ADDR);
        assign fwd_data[gi] = wdata_q;
    end

    assign o_fwd1_hit  = fwd_hit[0];
    assign o_fwd1_data = fwd_data[0];
    assign o_fwd2_hit  = fwd_hit[1];
    assign o_fwd2_data = fwd_data[1];
`else
    logic unused_raddr;
    assign unused_raddr = ^{i_raddr1, i_raddr2};

    assign o_fwd1_hit  = 1'b0;
    assign o_fwd1_data = '0;
    assign o_fwd2_hit  = 1'b0;
    assign o_fwd2_data = '0;
`endif

endmodule : wb_write_arbiter

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed vector table, starvation sequence and randomized traffic,
// all checked against a queue-based scoreboard of expected regfile writes.
module tb_wb_write_arbiter;
    import mips_pkg::*;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_alu_valid = 1'b0;
    logic [4:0]  i_alu_waddr = '0;
    logic [31:0] i_alu_wdata = '0;
    logic        i_md_valid = 1'b0;
    logic        o_md_ready;
    logic [4:0]  i_md_waddr = '0;
    logic [31:0] i_md_wdata = '0;
    logic        o_alu_stall;
    logic        o_we;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic [1:0]  o_md_count;
    logic [4:0]  i_raddr1 = '0;
    logic [4:0]  i_raddr2 = '0;
    logic        o_fwd1_hit;
    logic [31:0] o_fwd1_data;
    logic        o_fwd2_hit;
    logic [31:0] o_fwd2_data;

    wb_write_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .MD_DEPTH   (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_alu_valid (i_alu_valid),
        .i_alu_waddr (i_alu_waddr),
        .i_alu_wdata (i_alu_wdata),
        .i_md_valid  (i_md_valid),
        .o_md_ready  (o_md_ready),
        .i_md_waddr  (i_md_waddr),
        .i_md_wdata  (i_md_wdata),
        .o_alu_stall (o_alu_stall),
        .o_we        (o_we),
        .o_waddr     (o_waddr),
        .o_wdata     (o_wdata),
        .o_md_count  (o_md_count),
        .i_raddr1    (i_raddr1),
        .i_raddr2    (i_raddr2),
        .o_fwd1_hit  (o_fwd1_hit),
        .o_fwd1_data (o_fwd1_data),
        .o_fwd2_hit  (o_fwd2_hit),
        .o_fwd2_data (o_fwd2_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        all;
    } exp_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        int          r1;
        int          r2;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        int          ecnt;
    } vec_t;

    exp_t exp_q[$];
    ent_t md_model[$];
    int   starve_m = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // One cycle: drive inputs, predict the write, let the edge pass, compare. r1/r2 < 0 = random.
    task automatic step(input logic rst_v, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] mdat,
                        input int r1_sel, input int r2_sel, output logic accepted);
        exp_t e;
        ent_t h;
        logic rdy;
        logic nonempty;
        logic popped;
        logic exp_stall;
        logic [4:0] r1;
        logic [4:0] r2;
        if (o_alu_stall) av = 1'b0;
        i_rst = rst_v; i_alu_valid = av; i_alu_waddr = aa; i_alu_wdata = ad;
        i_md_valid = mv; i_md_waddr = ma; i_md_wdata = mdat;
        #1;
        rdy = o_md_ready;
        chk("md_ready", 32'(rdy), 32'(!rst_v && (md_model.size() < DEPTH)));
        accepted = mv & rdy;
        nonempty = (md_model.size() > 0);
        popped = 1'b0;
        if (rst_v) begin
            md_model.delete();
            starve_m = 0;
            e = '{we: 1'b0, addr: 5'd0, data: 32'd0, all: 1'b1};
        end else begin
            if (av) begin
                e = '{we: (aa != 5'd0), addr: aa, data: ad, all: 1'b0};
            end else if (nonempty) begin
                h = md_model.pop_front();
                popped = 1'b1;
                e = '{we: (h.a != 5'd0), addr: h.a, data: h.d, all: 1'b0};
            end else begin
                e = '{we: 1'b0, addr: 5'd0, data: 32'd0, all: 1'b0};
            end
            if (accepted) md_model.push_back('{a: ma, d: mdat});
            if (popped || !nonempty) starve_m = 0;
            else if (av && starve_m < SMAX) starve_m++;
        end
        exp_stall = (starve_m == SMAX);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("we", 32'(o_we), 32'(e.we));
        if (e.we || e.all) begin
            chk("waddr", 32'(o_waddr), 32'(e.addr));
            chk("wdata", o_wdata, e.data);
        end
        chk("md_count", 32'(o_md_count), 32'(md_model.size()));
        chk("alu_stall", 32'(o_alu_stall), 32'(exp_stall));
        r1 = (r1_sel >= 0) ? 5'(r1_sel) : ($urandom_range(0, 1) != 0 ? e.addr : 5'($urandom_range(0, 31)));
        r2 = (r2_sel >= 0) ? 5'(r2_sel) : 5'($urandom_range(0, 31));
        i_raddr1 = r1;
        i_raddr2 = r2;
        #1;
`ifdef WB_BYPASS_EN
        chk("fwd1_hit", 32'(o_fwd1_hit), 32'(e.we && (e.addr == r1) && (r1 != 5'd0)));
        chk("fwd2_hit", 32'(o_fwd2_hit), 32'(e.we && (e.addr == r2) && (r2 != 5'd0)));
        if (e.we) begin
            chk("fwd1_data", o_fwd1_data, e.data);
            chk("fwd2_data", o_fwd2_data, e.data);
        end
`else
        chk("fwd1_hit", 32'(o_fwd1_hit), 32'd0);
        chk("fwd2_hit", 32'(o_fwd2_hit), 32'd0);
        chk("fwd1_data", o_fwd1_data, 32'd0);
        chk("fwd2_data", o_fwd2_data, 32'd0);
`endif
    endtask

    vec_t vecs[12];

    initial begin
        logic acc;
        int   k;
        int   first_stall;
        logic [4:0]  ra, rm;
        logic [31:0] rd, rmd;

        //          rst   av    aa     ad        mv    ma      md        r1  r2  ewe   ea     ed       cnt
        vecs[0]  = '{1'b0, 1'b1, 5'd3,  32'd244,  1'b0, 5'd0,  32'd0,    3,  0, 1'b1, 5'd3,  32'd244, 0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0,  32'd0,    1'b0, 5'd0,  32'd0,   -1, -1, 1'b0, 5'd0,  32'd0,   0};
        vecs[2]  = '{1'b0, 1'b1, 5'd0,  32'd5,    1'b0, 5'd0,  32'd0,   -1, -1, 1'b0, 5'd0,  32'd0,   0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'd0,    1'b1, 5'd0,  32'd77,  -1, -1, 1'b0, 5'd0,  32'd0,   1};
        vecs[4]  = '{1'b0, 1'b0, 5'd0,  32'd0,    1'b0, 5'd0,  32'd0,   -1, -1, 1'b0, 5'd0,  32'd0,   0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'd0,    1'b1, 5'd9,  32'h99,  -1, -1, 1'b0, 5'd0,  32'd0,   1};
        vecs[6]  = '{1'b0, 1'b1, 5'd7,  32'd9,    1'b0, 5'd0,  32'd0,    7,  0, 1'b1, 5'd7,  32'd9,   1};
        vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'd0,    1'b1, 5'd10, 32'hA0,  -1, -1, 1'b1, 5'd9,  32'h99,  1};
        vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'd0,    1'b1, 5'd11, 32'hB0,  -1, -1, 1'b1, 5'd10, 32'hA0,  1};
        vecs[9]  = '{1'b0, 1'b1, 5'd4,  32'h44,   1'b1, 5'd12, 32'hC0,  -1, -1, 1'b1, 5'd4,  32'h44,  2};
        vecs[10] = '{1'b1, 1'b1, 5'd5,  32'd55,   1'b1, 5'd13, 32'hD0,  -1, -1, 1'b0, 5'd0,  32'd0,   0};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  32'd0,    1'b0, 5'd0,  32'd0,   -1, -1, 1'b0, 5'd0,  32'd0,   0};

        repeat (2) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 0, 0, acc);

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md,
                 vecs[i].r1, vecs[i].r2, acc);
            chk($sformatf("vec%0d_we", i), 32'(o_we), 32'(vecs[i].ewe));
            if (vecs[i].ewe) begin
                chk($sformatf("vec%0d_waddr", i), 32'(o_waddr), 32'(vecs[i].ea));
                chk($sformatf("vec%0d_wdata", i), o_wdata, vecs[i].ed);
            end
            chk($sformatf("vec%0d_count", i), 32'(o_md_count), 32'(vecs[i].ecnt));
        end

        // ALU busy every cycle while three mul/div results wait; the source holds each until accepted.
        k = 0;
        first_stall = -1;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b1, 5'(i + 1), 32'h1000 + 32'(i), (k < 3), 5'(20 + k), 32'h2000 + 32'(k), -1, -1, acc);
            if (acc) k++;
            if (o_alu_stall && first_stall < 0) first_stall = i;
        end
        chk("first_stall_cycle", 32'(first_stall), 32'd4);
        repeat (4) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, -1, -1, acc);
        chk("md_drained", 32'(o_md_count), 32'd0);

        // Randomized traffic with occasional resets; ALU obeys the stall inside step.
        for (int i = 0; i < 300; i++) begin
            ra  = 5'($urandom_range(0, 31));
            rd  = $urandom;
            rm  = 5'($urandom_range(0, 31));
            rmd = $urandom;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), ra, rd,
                 ($urandom_range(0, 1) != 0), rm, rmd, -1, -1, acc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_wb_write_arbiter
